serial_shift_ctrl: RTL and testbench
====================================

Name: serial_shift_ctrl

Overview:
- Multi-cycle shift sequencer for the execute stage. Serves SLL/SRL/SRA and SLLI/SRLI/SRAI.
- Drives the select line of the shift-amount operand mux:
  - sel=0 → 32-bit register operand.
  - sel=1 → zero-extended 5-bit immediate.
- Captures the mux output on start, shifts STEP bits per cycle, then reports completion with a one-cycle done pulse. A busy flag stalls the pipeline.

Parameters:
- STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8, 16.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a shift; sampled only in IDLE.
- use_imm  in  1  amount source for this request (1 = 5-bit immediate).
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- operand  in  32  value to shift.
- amt_in  in  32  output of the shift-amount mux; only bits [4:0] are used.
- amt_sel  out  1  select to the shift-amount mux.
- busy  out  1  high while a shift is in progress, including the DONE cycle.
- done  out  1  one-cycle completion pulse.
- result  out  32  shifted value; valid when done=1, held until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge, including mid-operation):
  - state→IDLE; busy=0, done=0, result=0, amt_sel=0.
  - Internal amount counter and latched op/amt_sel cleared.
  - Any shift in flight is abandoned with no done pulse.
- amt_sel:
  - In IDLE, combinationally equals use_imm, so amt_in settles in the start cycle.
  - In SHIFT and DONE, equals the use_imm value latched at accept.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge T (accept):
  - Latch operand into the work register, op, use_imm.
  - rem = amt_in[4:0] (5-bit, 0..31); amt_in[31:5] ignored.
  - If op=11: rem forced to 0 and result = operand unchanged.
  - rem=0 → DONE; else → SHIFT.
- SHIFT, each edge:
  - s = min(STEP, rem).
  - Shift the work register by s: logical left (SLL), logical right (SRL), or arithmetic right with the original bit 31 replicated (SRA).
  - rem = rem - s.
  - rem reaches 0 → DONE.
- DONE:
  - done=1, busy=1, result = work register.
  - Next edge → IDLE unconditionally.
- Latency:
  - k = ceil(amt/STEP); done is high in cycle T+1+k, with T the accept cycle.
  - amt=0 → done in cycle T+1.
  - STEP=1, amt=31 → done in T+32.
- busy = (state != IDLE); done = (state == DONE). Both are registered-state decodes, glitch-free.
- start while busy (SHIFT or DONE): ignored, no queuing. A start in the DONE cycle is dropped; the requester must hold start until busy=0.
- operand, amt_in and use_imm changing after accept: no effect.
- rst and start asserted at the same edge: rst wins.
- result is only updated in DONE; between operations it holds the last value.

Test Plan:
1. rst for 2 cycles, then idle → busy=0, done=0, result=0, amt_sel=0. Assert rst mid-SHIFT (STEP=1, amt=20, at cycle T+5) → IDLE next edge, no done pulse.
2. STEP=1, use_imm=1, amt_in=32'h0000_0004, op=SLL, operand=32'h0000_00F1, start at T → amt_sel=1 in T; done only in T+5 with result=32'h0000_0F10; busy high T+1..T+5.
3. STEP=1, use_imm=0, amt_in=32'hFFFF_FFE3 (amt=3), op=SRA, operand=32'h8000_0010 → amt_sel=0; done in T+4, result=32'hF000_0002. Same with op=SRL → 32'h1000_0002.
4. Boundaries:
   - amt=0, SLL, operand=32'hDEAD_BEEF → done in T+1, result unchanged.
   - STEP=1, amt=31, SRA, operand=32'h8000_0000 → done in T+32, result=32'hFFFF_FFFF.
   - op=11, amt=9 → done in T+1, result=operand.
5. STEP=4, amt=10, SRL, operand=32'hFFFF_FFFF → shifts 4,4,2; done in T+4, result=32'h003F_FFFF.
6. Handshake:
   - start held high through a whole operation: second accept occurs only in the first IDLE cycle after DONE, with no lost or duplicated done pulse.
   - operand and amt_in changed the cycle after accept → result unaffected.

Source files
------------

// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl
// -----------------
// Multi-cycle shift sequencer for the execute stage (SLL/SRL/SRA and the
// immediate forms). It drives the select of the shift-amount operand mux. On
// an accepted start it captures the mux output and the operand. It then
// shifts the working value by STEP bits per cycle. When the whole amount is
// consumed it shows a one-cycle done pulse.
//
// Parameters
//   STEP     bits shifted per cycle (1, 2, 4, 8 or 16)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    shift request, only looked at while idle
//   use_imm  amount source for this request (1 = 5-bit immediate)
//   op       00 SLL, 01 SRL, 10 SRA, 11 reserved (passes operand through)
//   operand  value to shift
//   amt_in   shift-amount mux output, only bits [4:0] are used
//   amt_sel  select to the shift-amount mux
//   busy     high from the cycle after accept through the done cycle
//   done     one-cycle completion pulse
//   result   shifted value, valid with done and held until the next one

module serial_shift_ctrl #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        use_imm,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [31:0] amt_in,
  output logic        amt_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      state;
  logic [31:0] work;
  logic [4:0]  rem;
  logic [1:0]  op_q;
  logic        sel_q;

  logic [4:0]  step_now;
  logic [4:0]  rem_next;
  logic [31:0] work_next;
  logic [4:0]  accept_amt;

  // Only the low five bits of the amount mux are meaningful for a 32-bit shift
  logic        unused_amt_hi;
  assign unused_amt_hi = ^amt_in[31:5];

  // The reserved opcode behaves like a zero-length shift. The value then
  // goes straight to DONE unchanged.
  assign accept_amt = (op == 2'b11) ? 5'd0 : amt_in[4:0];

  // One shift step: the smaller of STEP and the remaining amount. For SRA,
  // the arithmetic shift keeps bit 31 in place on every step. So the sign
  // that gets replicated is always the original operand's bit 31.
  always_comb begin
    step_now  = (rem < STEP_AMT) ? rem : STEP_AMT;
    rem_next  = rem - step_now;
    work_next = work;
    case (op_q)
      2'b00:   work_next = work << step_now;
      2'b01:   work_next = work >> step_now;
      2'b10:   work_next = $unsigned($signed(work) >>> step_now);
      default: work_next = work;
    endcase
  end

  // Sequencer: IDLE -> (SHIFT ->)* DONE -> IDLE. The result register is
  // loaded on the edge that enters DONE. So it is already valid in the done
  // cycle, and it keeps that value until the next operation finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      rem    <= '0;
      op_q   <= '0;
      sel_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= operand;
            op_q  <= op;
            sel_q <= use_imm;
            rem   <= accept_amt;
            if (accept_amt == 5'd0) begin
              state  <= DONE;
              result <= operand;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          rem  <= rem_next;
          if (rem_next == 5'd0) begin
            state  <= DONE;
            result <= work_next;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // While idle the mux select follows the request directly. This lets the
  // amount settle within the start cycle. Afterwards it holds the latched
  // choice, so later changes to use_imm are ignored.
  assign amt_sel = (state == IDLE) ? use_imm : sel_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// tb_serial_shift_ctrl
// --------------------
// Drives a STEP=1 instance (index 0) and a STEP=4 instance (index 1) with the
// same inputs. A timing-level model predicts the outputs of both instances.
// The model works from the accept cycle, the done cycle (accept + 1 +
// ceil(amt/STEP)) and a whole-amount shift. Directed cases also pin latency
// and result against hand-computed literals.

module tb_serial_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        use_imm;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [31:0] amt_in;

  logic [1:0]  sel_v;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [31:0] res_v [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          m_active  [2];
  int          m_done_at [2];
  logic [31:0] m_pending [2];
  logic [31:0] m_result  [2];
  bit          m_sel     [2];

  serial_shift_ctrl #(.STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .use_imm(use_imm), .op(op),
    .operand(operand), .amt_in(amt_in), .amt_sel(sel_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0])
  );

  serial_shift_ctrl #(.STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .use_imm(use_imm), .op(op),
    .operand(operand), .amt_in(amt_in), .amt_sel(sel_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1])
  );

  always #5 clk = ~clk;

  // Whole-amount reference shift
  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] v, int a);
    case (o)
      2'b00:   return v << a;
      2'b01:   return v >> a;
      2'b10:   return $unsigned($signed(v) >>> a);
      default: return v;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model update: decide accept / completion at each edge, then advance the
  // cycle count. The result becomes visible at the start of the done cycle.
  always @(posedge clk) begin
    int st;
    int a;
    for (int i = 0; i < 2; i++) begin
      st = (i == 0) ? 1 : 4;
      if (rst) begin
        m_active[i] = 1'b0;
        m_result[i] = '0;
        m_sel[i]    = 1'b0;
      end else if (!m_active[i]) begin
        if (start) begin
          a = (op == 2'b11) ? 0 : int'(amt_in[4:0]);
          m_active[i]  = 1'b1;
          m_done_at[i] = cyc + 1 + (a + st - 1) / st;
          m_pending[i] = ref_shift(op, operand, a);
          m_sel[i]     = use_imm;
        end
      end else if (cyc == m_done_at[i]) begin
        m_active[i] = 1'b0;
      end
    end
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (m_active[i] && cyc == m_done_at[i]) m_result[i] = m_pending[i];
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_active[i]));
        checkOutput($sformatf("done[%0d]", i), 32'(done_v[i]),
                    32'(m_active[i] && cyc == m_done_at[i]));
        checkOutput($sformatf("result[%0d]", i), res_v[i], m_result[i]);
        checkOutput($sformatf("amt_sel[%0d]", i), 32'(sel_v[i]),
                    32'(m_active[i] ? m_sel[i] : use_imm));
      end
    end
  end

  task automatic applyStimulus(bit imm, logic [31:0] amt, logic [1:0] o, logic [31:0] opd);
    use_imm = imm;
    amt_in  = amt;
    op      = o;
    operand = opd;
    start   = 1'b1;
  endtask

  task automatic waitIdle(string name);
    int k = 0;
    while (busy_v != 2'b00 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({name, " idle"}, 32'(busy_v), 32'd0);
    @(posedge clk); #1;
  endtask

  // One request, called at posedge+1 with both instances idle
  task automatic runOp(string name, bit imm, logic [31:0] amt, logic [1:0] o,
                       logic [31:0] opd, int which, int exp_lat, logic [31:0] exp_res);
    int lat = 0;
    applyStimulus(imm, amt, o, opd);
    #1;
    checkOutput({name, " amt_sel"}, 32'(sel_v[which]), 32'(imm));
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done_v[which]) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, " result"}, res_v[which], exp_res);
    waitIdle(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; use_imm = 1'b0; op = 2'b00;
    operand = '0; amt_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      checkOutput("reset busy", 32'(busy_v[i]), 32'd0);
      checkOutput("reset done", 32'(done_v[i]), 32'd0);
      checkOutput("reset result", res_v[i], 32'd0);
      checkOutput("reset amt_sel", 32'(sel_v[i]), 32'd0);
    end
    @(posedge clk); #1;

    runOp("sll imm4", 1'b1, 32'h0000_0004, 2'b00, 32'h0000_00F1, 0, 5, 32'h0000_0F10);
    runOp("sra reg3", 1'b0, 32'hFFFF_FFE3, 2'b10, 32'h8000_0010, 0, 4, 32'hF000_0002);
    runOp("srl reg3", 1'b0, 32'hFFFF_FFE3, 2'b01, 32'h8000_0010, 0, 4, 32'h1000_0002);
    runOp("amt zero", 1'b0, 32'h0000_0000, 2'b00, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF);
    runOp("sra 31",   1'b1, 32'h0000_001F, 2'b10, 32'h8000_0000, 0, 32, 32'hFFFF_FFFF);
    runOp("op11",     1'b0, 32'h0000_0009, 2'b11, 32'h1234_5678, 0, 1, 32'h1234_5678);
    runOp("step4 srl10", 1'b0, 32'h0000_000A, 2'b01, 32'hFFFF_FFFF, 1, 4, 32'h003F_FFFF);

    // Reset in the middle of a long shift: no done pulse may follow
    applyStimulus(1'b1, 32'd20, 2'b00, 32'h0000_0001);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst busy", 32'(busy_v), 32'd0);
    checkOutput("midrst result", res_v[0], 32'd0);
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      if (done_v != 2'b00) cnt++;
      @(posedge clk); #1;
    end
    checkOutput("midrst no done", 32'(cnt), 32'd0);

    // start held high: exactly two completions on the STEP=1 instance
    applyStimulus(1'b0, 32'd2, 2'b00, 32'h0000_0003);
    cnt = 0;
    for (int n = 0; n < 13; n++) begin
      if (n == 5) start = 1'b0;
      if (done_v[0]) cnt++;
      @(posedge clk); #1;
    end
    checkOutput("held start pulses", 32'(cnt), 32'd2);
    checkOutput("held start result", res_v[0], 32'h0000_000C);
    waitIdle("held start");

    // Inputs changed right after accept must not disturb the operation
    applyStimulus(1'b1, 32'd5, 2'b01, 32'hF000_0000);
    @(posedge clk); #1;
    start = 1'b0; operand = 32'h0000_1234; amt_in = '0; use_imm = 1'b0; op = 2'b00;
    #1 checkOutput("late change amt_sel", 32'(sel_v[0]), 32'd1);
    cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done_v[0]) begin
        cnt = n;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("late change latency", 32'(cnt), 32'd6);
    checkOutput("late change result", res_v[0], 32'h0780_0000);
    waitIdle("late change");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
